// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and register-index constants shared by the pipeline sequencer.
package pipe_ctrl_pkg;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam int DEF_REG_ADDR_BITS = 5;
  localparam logic [DEF_REG_ADDR_BITS-1:0] ZERO_REG = '0;
  typedef enum logic [1:0] {RUN = S_RUN, DRAIN = S_DRAIN, HALTED = S_HALTED} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and pipeline-register enable/clear controls.
interface pipe_hazard_ctrl_if #(parameter int REG_ADDR_BITS = pipe_ctrl_pkg::DEF_REG_ADDR_BITS);
  logic [REG_ADDR_BITS-1:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_syscall, resume;
  logic pc_en, ifid_en, ifid_clr, idex_clr, exmem_en, memwb_en, halted;
  modport master(
    output id_rs, id_rt, ex_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_syscall, resume,
    input pc_en, ifid_en, ifid_clr, idex_clr, exmem_en, memwb_en, halted
  );
  modport slave(
    input id_rs, id_rt, ex_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_syscall, resume,
    output pc_en, ifid_en, ifid_clr, idex_clr, exmem_en, memwb_en, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the nonzero destination of a load in EX.
module load_use_detect import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDR_BITS = DEF_REG_ADDR_BITS
) (
  input  logic [REG_ADDR_BITS-1:0] id_rs,
  input  logic [REG_ADDR_BITS-1:0] id_rt,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic                     ex_mem_read,
  input  logic [REG_ADDR_BITS-1:0] ex_rt,
  output logic                     hazard
);
  assign hazard = ex_mem_read && ex_rt != REG_ADDR_BITS'(ZERO_REG) &&
                  ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline register sequencing for load-use stall, branch flush and syscall drain/halt.
// Optional stall/flush performance counters are built when PERF_CNT_EN is defined.
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDR_BITS = DEF_REG_ADDR_BITS,
  parameter int DRAIN_CYCLES = 3
`ifdef PERF_CNT_EN
  , parameter int CNT_BITS = 32
`endif
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
`ifdef PERF_CNT_EN
  , output logic [CNT_BITS-1:0] stall_cnt
  , output logic [CNT_BITS-1:0] flush_cnt
`endif
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  state_t state, state_nxt;
  logic [DW-1:0] drain_cnt;
  logic lu, pc_en, ifid_en, ifid_clr, idex_clr, exmem_en, memwb_en;
  load_use_detect #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_lud (
    .id_rs(bus.id_rs), .id_rt(bus.id_rt), .id_uses_rs(bus.id_uses_rs), .id_uses_rt(bus.id_uses_rt),
    .ex_mem_read(bus.ex_mem_read), .ex_rt(bus.ex_rt), .hazard(lu)
  );
  always_ff @(posedge clk) begin
    state <= state_nxt;
    drain_cnt <= (rst || state != DRAIN) ? '0 : drain_cnt + 1'b1;
  end
  always_comb begin
    state_nxt = state;
    pc_en = 1'b1;
    ifid_en = 1'b1;
    ifid_clr = 1'b0;
    idex_clr = 1'b0;
    exmem_en = 1'b1;
    memwb_en = 1'b1;
    case (state)
      RUN: begin
        state_nxt = bus.ex_syscall ? DRAIN : RUN;
        pc_en = !(bus.ex_syscall || (!bus.ex_br_taken && lu));
        ifid_en = pc_en;
        ifid_clr = !bus.ex_syscall && bus.ex_br_taken;
        idex_clr = bus.ex_syscall || bus.ex_br_taken || lu;
      end
      DRAIN: begin
        state_nxt = drain_cnt == DW'(DRAIN_CYCLES - 1) ? HALTED : DRAIN;
        pc_en = 1'b0;
        ifid_en = 1'b0;
        idex_clr = 1'b1;
      end
      HALTED: begin
        state_nxt = bus.resume ? RUN : HALTED;
        pc_en = 1'b0;
        ifid_en = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) begin
      state_nxt = RUN;
      pc_en = 1'b0;
      ifid_en = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end
  end
  assign bus.pc_en = pc_en;
  assign bus.ifid_en = ifid_en;
  assign bus.ifid_clr = ifid_clr;
  assign bus.idex_clr = idex_clr;
  assign bus.exmem_en = exmem_en;
  assign bus.memwb_en = memwb_en;
  assign bus.halted = state == HALTED;
`ifdef PERF_CNT_EN
  // Counters saturate rather than wrap so a long run never reports a small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == RUN && !bus.ex_syscall) begin
      if (bus.ex_br_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (!bus.ex_br_taken && lu && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, flush, drain/halt, resume and reset behaviour.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  pipe_hazard_ctrl_if #(.REG_ADDR_BITS(5)) bus ();
`ifdef PERF_CNT_EN
  logic [3:0] stall_cnt, flush_cnt;
`endif
  pipe_hazard_ctrl #(
    .REG_ADDR_BITS(5), .DRAIN_CYCLES(3)
`ifdef PERF_CNT_EN
    , .CNT_BITS(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.ex_rt = '0;
    bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.ex_mem_read = 0;
    bus.ex_br_taken = 0; bus.ex_syscall = 0; bus.resume = 0;
  endtask
  task automatic load_rs(input logic [4:0] r);
    bus.ex_mem_read = 1; bus.ex_rt = r; bus.id_rs = r; bus.id_uses_rs = 1;
  endtask
  task automatic next();
    @(negedge clk);
    idle();
  endtask
  task automatic ctl(input string tag, input logic [5:0] exp);
    #1 chk(tag, {bus.pc_en, bus.ifid_en, bus.ifid_clr, bus.idex_clr, bus.exmem_en, bus.memwb_en}, exp);
  endtask
  // expected vectors: {pc_en, ifid_en, ifid_clr, idex_clr, exmem_en, memwb_en}
  localparam logic [5:0] V_RST = 6'b001100, V_RUN = 6'b110011, V_STALL = 6'b000111,
                         V_FLUSH = 6'b111111, V_FRONT = 6'b000111, V_HALT = 6'b000000;
  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    @(negedge clk);
    ctl("reset_ctl", V_RST);
    chk("reset_halted", bus.halted, 0);
    rst = 0;
    ctl("run_ctl", V_RUN);
    next(); load_rs(5'd5);
    ctl("lu_rs_stall", V_STALL);
    next();
    ctl("lu_one_cycle", V_RUN);
`ifdef PERF_CNT_EN
    chk("stall_cnt_1", stall_cnt, 1);
`endif
    next(); load_rs(5'd0);
    ctl("lu_r0_nostall", V_RUN);
    next(); bus.ex_mem_read = 1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1;
    ctl("lu_rt_stall", V_STALL);
    next(); bus.ex_mem_read = 1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7;
    ctl("lu_rt_unused", V_RUN);
    next(); load_rs(5'd5); bus.ex_br_taken = 1;
    ctl("br_over_lu", V_FLUSH);
`ifdef PERF_CNT_EN
    chk("stall_cnt_2", stall_cnt, 2);
`endif
    next();
    ctl("after_flush", V_RUN);
`ifdef PERF_CNT_EN
    chk("flush_cnt_1", flush_cnt, 1);
    chk("stall_cnt_keep", stall_cnt, 2);
`endif
    next(); bus.ex_syscall = 1; bus.ex_br_taken = 1;
    ctl("syscall_ctl", V_STALL);
    next();
    ctl("drain1", V_FRONT);
    chk("drain1_halted", bus.halted, 0);
    next(); bus.ex_br_taken = 1; bus.resume = 1;
    ctl("drain2_ignore", V_FRONT);
    next();
    ctl("drain3", V_FRONT);
    chk("drain3_halted", bus.halted, 0);
    next();
    ctl("halt_ctl", V_HALT);
    chk("halted_1", bus.halted, 1);
`ifdef PERF_CNT_EN
    chk("flush_cnt_sys", flush_cnt, 1);
`endif
    next();
    chk("halted_hold", bus.halted, 1);
    bus.resume = 1;
    #1 chk("halted_resume_pre", bus.halted, 1);
    next();
    ctl("resumed_ctl", V_RUN);
    chk("resumed_halted", bus.halted, 0);
    bus.resume = 1;
    next();
    chk("resume_in_run", bus.halted, 0);
    ctl("resume_in_run_ctl", V_RUN);
    for (int i = 0; i < 20; i++) begin
      next(); load_rs(5'd9);
    end
    next();
`ifdef PERF_CNT_EN
    #1 chk("stall_cnt_sat", stall_cnt, 15);
`endif
    bus.ex_syscall = 1;
    next(); bus.resume = 1;
    ctl("drain_a", V_FRONT);
    next();
    next();
    #1 chk("drain_c_halted", bus.halted, 0);
    next();
    chk("halted_after_lost_resume", bus.halted, 1);
    rst = 1;
    ctl("rst_in_halt_ctl", V_RST);
    next(); rst = 0;
    ctl("rst_to_run_ctl", V_RUN);
    chk("rst_to_run_halted", bus.halted, 0);
`ifdef PERF_CNT_EN
    chk("stall_cnt_rst", stall_cnt, 0);
    chk("flush_cnt_rst", flush_cnt, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
